l1_icache: RTL

- Direct-mapped, read-only L1 instruction cache. It sits between the core fetch stage and one consumer port of the shared L2 SystemBus.
- Hits return one 32-bit word. Misses refill a full 128-bit line from L2 over the bus read handshake.
- It services L2 invalidation broadcasts so fetched code stays coherent with data-side writes. It supports a full flush for fence.i.

---
 rtl/l1_icache.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/l1_icache.sv
// Direct-mapped, read-only L1 instruction cache with line refill from an L2
// bus port, L2-driven line invalidation and a whole-cache flush for fence.i.
module l1_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int LINES      = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req_valid,
    input  logic [ADDR_WIDTH-1:0]             cpu_req_addr,
    output logic                              cpu_req_ready,
    input  logic                              cpu_flush,
    output logic                              cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]             cpu_resp_data,
    output logic                              bus_rw_valid,
    output logic                              bus_we,
    output logic [ADDR_WIDTH-1:0]             bus_rw_addr,
    output logic [LINE_WIDTH-1:0]             bus_wdata,
    output logic [$clog2(LINE_WIDTH/8)-1:0]   bus_w_mask,
    output logic                              bus_w_ce,
    input  logic                              bus_rw_ready,
    input  logic [LINE_WIDTH-1:0]             bus_r_data,
    input  logic                              bus_inv_valid,
    input  logic [ADDR_WIDTH-1:0]             bus_inv_addr,
    output logic                              bus_inv_ready
);
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam int IDX   = $clog2(LINES);
    localparam int TAGW  = ADDR_WIDTH - OFF - IDX;
    localparam int WORDS = LINE_WIDTH / DATA_WIDTH;
    localparam int WSEL  = OFF - 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-3:0]   addr_reg;
    logic [LINES-1:0]        valid_reg;
    logic                    poison_reg;
    logic [LINE_WIDTH-1:0]   line_reg;
    logic [TAGW-1:0]         tag_mem  [LINES];
    logic [LINE_WIDTH-1:0]   data_mem [LINES];

    logic [ADDR_WIDTH-OFF-1:0] line_addr;
    logic [ADDR_WIDTH-1:0]     line_addr_full;
    logic [IDX-1:0]            idx;
    logic [TAGW-1:0]           tag;
    logic [WSEL-1:0]           wsel;
    logic [LINE_WIDTH-1:0]     hit_line;
    logic                      hit;
    logic                      poison_next;
    logic                      refill_done;
    logic [IDX-1:0]            inv_idx;
    logic [TAGW-1:0]           inv_tag;
    logic                      inv_hit;
    logic                      unused_bits;

    assign unused_bits    = &{1'b0, cpu_req_addr[1:0]};
    assign line_addr      = addr_reg[ADDR_WIDTH-3:OFF-2];
    assign line_addr_full = {{OFF{1'b0}}, line_addr};
    assign idx            = addr_reg[OFF+IDX-3:OFF-2];
    assign tag            = addr_reg[ADDR_WIDTH-3:OFF+IDX-2];
    assign wsel           = addr_reg[OFF-3:0];
    assign hit_line       = data_mem[idx];
    assign hit            = valid_reg[idx] && (tag_mem[idx] == tag);

    assign inv_idx = bus_inv_addr[IDX-1:0];
    assign inv_tag = bus_inv_addr[ADDR_WIDTH-OFF-1:IDX];
    assign inv_hit = bus_inv_valid && valid_reg[inv_idx] && (tag_mem[inv_idx] == inv_tag);

    // An invalidation of the line being refilled must leave that line invalid.
    assign poison_next = poison_reg || (bus_inv_valid && (bus_inv_addr == line_addr_full));
    assign refill_done = (state_reg == REFILL) && bus_rw_ready;

    logic [DATA_WIDTH-1:0] hit_words  [WORDS];
    logic [DATA_WIDTH-1:0] resp_words [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign hit_words[gi]  = hit_line[gi*DATA_WIDTH +: DATA_WIDTH];
            assign resp_words[gi] = line_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            valid_reg  <= '0;
            poison_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!cpu_flush && cpu_req_valid) begin
                        addr_reg  <= cpu_req_addr[ADDR_WIDTH-1:2];
                        state_reg <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    poison_reg <= 1'b0;
                    state_reg  <= hit ? IDLE : REFILL;
                end
                REFILL: begin
                    poison_reg <= poison_next;
                    if (bus_rw_ready) begin
                        line_reg  <= bus_r_data;
                        state_reg <= RESP;
                    end
                end
                RESP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // Refill write comes last so it wins over an invalidation of the old line at its index.
            if (state_reg == IDLE && cpu_flush) begin
                valid_reg <= '0;
            end else begin
                if (inv_hit) begin
                    valid_reg[inv_idx] <= 1'b0;
                end
                if (refill_done) begin
                    valid_reg[idx] <= !poison_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && refill_done) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= bus_r_data;
        end
    end

    always_comb begin
        cpu_req_ready  = !rst && (state_reg == IDLE) && !cpu_flush;
        cpu_resp_valid = 1'b0;
        cpu_resp_data  = '0;
        if (!rst && state_reg == LOOKUP && hit) begin
            cpu_resp_valid = 1'b1;
            cpu_resp_data  = hit_words[wsel];
        end else if (!rst && state_reg == RESP) begin
            cpu_resp_valid = 1'b1;
            cpu_resp_data  = resp_words[wsel];
        end
        bus_rw_valid  = !rst && (state_reg == REFILL);
        bus_rw_addr   = bus_rw_valid ? line_addr_full : '0;
        bus_inv_ready = !rst && bus_inv_valid;
    end

    assign bus_we     = 1'b0;
    assign bus_wdata  = '0;
    assign bus_w_mask = '0;
    assign bus_w_ce   = 1'b0;

endmodule
